// File: rtl/mtl_pixel_prefetch.sv
// mtl_pixel_prefetch: burst prefetcher feeding a show-ahead pixel FIFO for the display timing stage.
// One burst is outstanding at most; FIFO space for it is reserved before the request goes out.
module mtl_pixel_prefetch #(
    parameter int DEPTH    = 64,
    parameter int BURST    = 16,
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 22,
    parameter int FB_BASE  = 0
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iNew_Frame,
    input  logic              iRead_en,
    output logic [31:0]       oREAD_DATA,
    output logic              oMem_req,
    output logic [ADDR_W-1:0] oMem_addr,
    input  logic              iMem_gnt,
    input  logic [31:0]       iMem_rdata,
    input  logic              iMem_rvalid,
    output logic              oUnderflow,
    output logic              oFrame_done
);
    localparam int TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int BW    = $clog2(BURST);
    localparam int WW    = $clog2(TOTAL + 1);

    typedef enum logic [2:0] {IDLE, REQ, RECV, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [WW-1:0]     words_req_q, words_req_d, words_rcv_q, words_rcv_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d, underflow_q, underflow_d, done_q, done_d;
    logic [31:0]       mem [DEPTH];
    logic              empty, push, pop, last_beat;

    assign empty       = count_q == '0;
    assign last_beat   = iMem_rvalid && beat_q == BW'(BURST - 1);
    assign push        = state_q == RECV && iMem_rvalid && !iNew_Frame;
    assign pop         = iRead_en && !empty && !iNew_Frame;
    assign oREAD_DATA  = empty ? '0 : mem[rd_ptr_q];
    assign oMem_req    = req_q;
    assign oMem_addr   = addr_q;
    assign oUnderflow  = underflow_q;
    assign oFrame_done = done_q;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q + AW'(push);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        count_d     = count_q + CW'(push) - CW'(pop);
        beat_d      = beat_q;
        words_req_d = words_req_q;
        words_rcv_d = words_rcv_q + WW'(push);
        addr_d      = addr_q;
        req_d       = req_q;
        underflow_d = underflow_q | (iRead_en & empty);
        done_d      = done_q;
        case (state_q)
            IDLE: if (words_req_q < WW'(TOTAL) && count_q <= CW'(DEPTH - BURST)) begin
                state_d = REQ;
                req_d   = 1'b1;
            end else if (words_rcv_q == WW'(TOTAL)) begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            REQ: if (iMem_gnt) begin
                state_d     = RECV;
                req_d       = 1'b0;
                addr_d      = addr_q + ADDR_W'(BURST);
                words_req_d = words_req_q + WW'(BURST);
                beat_d      = '0;
            end
            RECV, DRAIN: if (iMem_rvalid) begin
                beat_d  = beat_q + BW'(1);
                state_d = last_beat ? IDLE : state_q;
            end
            default: ;
        endcase
        // A frame restart keeps counting beats of an already accepted burst so they are swallowed
        if (iNew_Frame) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            addr_d      = ADDR_W'(FB_BASE);
            words_req_d = '0;
            words_rcv_d = '0;
            underflow_d = 1'b0;
            done_d      = 1'b0;
            req_d       = 1'b0;
            state_d     = ((state_q == REQ && iMem_gnt) ||
                           ((state_q == RECV || state_q == DRAIN) && !last_beat)) ? DRAIN : IDLE;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            beat_q      <= '0;
            words_req_q <= '0;
            words_rcv_q <= '0;
            addr_q      <= ADDR_W'(FB_BASE);
            req_q       <= 1'b0;
            underflow_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            beat_q      <= beat_d;
            words_req_q <= words_req_d;
            words_rcv_q <= words_rcv_d;
            addr_q      <= addr_d;
            req_q       <= req_d;
            underflow_q <= underflow_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge iCLK) begin
        if (push) mem[wr_ptr_q] <= iMem_rdata;
    end
endmodule

// File: tb/tb_mtl_pixel_prefetch.sv
// tb_mtl_pixel_prefetch: randomized scoreboard bench; a small frame keeps whole-frame streams short.
// Memory answers each burst with pix(address); the display must see pix(FB_BASE + i) in order.
module tb_mtl_pixel_prefetch;
    localparam int DEPTH    = 64;
    localparam int BURST    = 16;
    localparam int H_ACTIVE = 32;
    localparam int V_ACTIVE = 8;
    localparam int ADDR_W   = 8;
    localparam int FB_BASE  = 200;
    localparam int TOTAL    = H_ACTIVE * V_ACTIVE;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_BASE + TOTAL - BURST);

    logic              clk = 1'b0;
    logic              rst_n, new_frame, read_en, mem_req, mem_gnt, mem_rvalid, underflow, frame_done;
    logic [31:0]       read_data, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;

    int          compared = 0, mismatched = 0, uf_reads = 0;
    int          bursts_acc = 0, beats_left = 0, gnt_wait = 0;
    bit          mem_stall = 0;
    logic [31:0] exp_q[$];
    logic [ADDR_W-1:0] exp_addr, beat_addr, last_addr;

    mtl_pixel_prefetch #(
        .DEPTH(DEPTH), .BURST(BURST), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
        .ADDR_W(ADDR_W), .FB_BASE(FB_BASE)
    ) dut (
        .iCLK(clk), .iRST_n(rst_n), .iNew_Frame(new_frame), .iRead_en(read_en),
        .oREAD_DATA(read_data), .oMem_req(mem_req), .oMem_addr(mem_addr),
        .iMem_gnt(mem_gnt), .iMem_rdata(mem_rdata), .iMem_rvalid(mem_rvalid),
        .oUnderflow(underflow), .oFrame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pix(logic [ADDR_W-1:0] a);
        return 32'h00A00000 | 32'(a);
    endfunction

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Memory: grant two cycles into a request, then one burst of pix(addr) beats with random gaps
    initial begin
        bit acc;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; exp_addr = ADDR_W'(FB_BASE);
        forever begin
            @(negedge clk);
            acc = rst_n && mem_req && mem_gnt;
            if (acc) begin
                check("req_addr", 32'(mem_addr), 32'(exp_addr));
                last_addr = mem_addr;
                exp_addr = exp_addr + ADDR_W'(BURST);
                bursts_acc++;
            end
            if (!rst_n || new_frame) exp_addr = ADDR_W'(FB_BASE);
            @(posedge clk);
            #1;
            if (acc) begin
                beats_left = BURST;
                beat_addr = last_addr;
            end
            mem_rvalid = 0;
            if (beats_left > 0 && $urandom_range(0, 7) != 0) begin
                mem_rvalid = 1;
                mem_rdata = pix(beat_addr);
                beat_addr++;
                beats_left--;
            end
            if (acc || !mem_req || mem_stall || beats_left > 0) begin
                mem_gnt = 0;
                gnt_wait = 0;
            end else begin
                gnt_wait++;
                if (gnt_wait >= 2) mem_gnt = 1;
            end
        end
    end

    // Monitor: every non-zero word read must be the next pixel of the frame
    initial forever begin
        @(negedge clk);
        if (rst_n && read_en && !new_frame) begin
            if (read_data == 0) uf_reads++;
            else if (exp_q.size() == 0) check("extra_pixel", read_data, 0);
            else check("pixel", read_data, exp_q.pop_front());
        end
    end

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        new_frame = 1;
        exp_q.delete();
        for (int i = 0; i < TOTAL; i++) exp_q.push_back(pix(ADDR_W'(FB_BASE + i)));
        @(posedge clk);
        #1;
        new_frame = 0;
    endtask

    task automatic start_frame();
        @(posedge clk);
        #1;
        pulse_frame();
    endtask

    task automatic read_n(int n);
        for (int i = 0; i < n; i++) begin
            read_en = 1;
            @(posedge clk);
            #1;
        end
        read_en = 0;
    endtask

    task automatic stream();
        idle(100);
        for (int n = 0; n < 4000 && exp_q.size() > 0; n++) begin
            read_en = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        read_en = 0;
        check("stream_left", exp_q.size(), 0);
        idle(5);
    endtask

    task automatic check_frame(int b0, int u0);
        check("frame_uf_reads", uf_reads - u0, 0);
        check("frame_underflow", underflow, 0);
        check("frame_done", frame_done, 1);
        check("frame_last_addr", 32'(last_addr), 32'(LAST_ADDR));
        check("frame_bursts", bursts_acc - b0, TOTAL / BURST);
    endtask

    task automatic wait_gnt_abort(int b0, output bit found);
        found = 0;
        for (int n = 0; n < 300 && !found; n++) begin
            @(posedge clk);
            #2;
            found = bursts_acc - b0 >= 1 && mem_gnt && mem_req;
        end
    endtask

    task automatic wait_recv(int b0, int left_max, output bit found);
        found = 0;
        for (int n = 0; n < 300 && !found; n++) begin
            @(posedge clk);
            #2;
            found = bursts_acc - b0 >= 1 && beats_left > 0 && beats_left <= left_max;
        end
    endtask

    initial begin
        int b0, u0;
        bit found;
        rst_n = 0; new_frame = 0; read_en = 0;
        idle(3);
        check("rst_req", mem_req, 0);
        check("rst_addr", 32'(mem_addr), FB_BASE);
        check("rst_data", read_data, 0);
        check("rst_uf", underflow, 0);
        check("rst_done", frame_done, 0);
        rst_n = 1;
        idle(2);

        // Fill: four bursts, no fifth until sixteen words have left
        start_frame();
        check("fill_done_low", frame_done, 0);
        b0 = bursts_acc;
        idle(150);
        check("fill_bursts", bursts_acc - b0, 4);
        check("fill_req_low", mem_req, 0);
        read_n(15);
        idle(40);
        check("fill_bursts_15pop", bursts_acc - b0, 4);
        read_n(1);
        idle(40);
        check("fill_bursts_16pop", bursts_acc - b0, 5);

        // Whole frame with random display reads
        start_frame();
        b0 = bursts_acc; u0 = uf_reads;
        stream();
        check_frame(b0, u0);

        // Memory stalled: reads return zero, underflow is sticky until the next frame
        mem_stall = 1;
        start_frame();
        u0 = uf_reads;
        read_n(5);
        idle(3);
        check("uf_set", underflow, 1);
        check("uf_reads", uf_reads - u0, 5);
        check("uf_data", read_data, 0);
        idle(5);
        check("uf_sticky", underflow, 1);
        mem_stall = 0;
        start_frame();
        check("uf_clear", underflow, 0);
        b0 = bursts_acc; u0 = uf_reads;
        stream();
        check_frame(b0, u0);

        // Restart five beats into a burst: the rest must be drained, not pushed
        start_frame();
        wait_recv(bursts_acc, BURST - 5, found);
        check("abort_recv_reached", found, 1);
        pulse_frame();
        b0 = bursts_acc; u0 = uf_reads;
        stream();
        check_frame(b0, u0);

        // Restart on the very cycle a request is granted
        start_frame();
        wait_gnt_abort(bursts_acc, found);
        check("abort_gnt_reached", found, 1);
        pulse_frame();
        b0 = bursts_acc; u0 = uf_reads;
        stream();
        check_frame(b0, u0);

        // Asynchronous reset mid-burst, stray beats after release
        start_frame();
        wait_recv(bursts_acc, BURST - 1, found);
        check("reset_recv_reached", found, 1);
        #1;
        rst_n = 0;
        #1;
        check("arst_req", mem_req, 0);
        check("arst_addr", 32'(mem_addr), FB_BASE);
        check("arst_data", read_data, 0);
        check("arst_uf", underflow, 0);
        check("arst_done", frame_done, 0);
        exp_q.delete();
        idle(2);
        rst_n = 1;
        idle(60);
        start_frame();
        b0 = bursts_acc; u0 = uf_reads;
        stream();
        check_frame(b0, u0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached with %0d words outstanding", exp_q.size());
        $fatal(1);
    end
endmodule
